// File: rtl/exc_pkg.sv
// Shared exception-unit types: FSM state encoding, ExcCode values and the default handler vector.
package exc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_VEC,
    S_HANDLER,
    S_RET
  } exc_state_e;

  // ExcCode space is 5 bits; further causes slot in beside these.
  localparam logic [4:0]  EXC_NONE        = 5'd0;
  localparam logic [4:0]  EXC_OV          = 5'd12;
  localparam logic [31:0] HANDLER_VEC_DEF = 32'h8000_0180;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/overflow_exception_unit.sv
// Precise trap on signed add/sub overflow: flush, capture EPC/Cause, vector to the handler,
// and return to EPC on ERET. All outputs come straight from registers.
module overflow_exception_unit
  import exc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(HANDLER_VEC_DEF),
  parameter logic [4:0]        EXC_CODE_OV = EXC_OV,
  parameter int                CNT_W       = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_valid_i,
  input  logic              trap_en_i,
  input  logic              ovf_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              eret_i,
  input  logic              pc_ack_i,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [ADDR_W-1:0] epc_o,
  output logic [4:0]        cause_o,
  output logic              exl_o,
  output logic [CNT_W-1:0]  missed_cnt_o
);

  exc_state_e        state_q;
  logic              flush_q, redir_q, exl_q;
  logic [ADDR_W-1:0] redir_pc_q, epc_q;
  logic [4:0]        cause_q;
  logic              trig, missed;

  assign trig   = ex_valid_i & trap_en_i & ovf_i;
  // Anything but IDLE means a handler is live or a redirect is in flight.
  assign missed = trig & (state_q != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      flush_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      epc_q      <= '0;
      cause_q    <= EXC_NONE;
      exl_q      <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (trig) begin
          state_q <= S_FLUSH;
          flush_q <= 1'b1;
          epc_q   <= ex_pc_i;
          cause_q <= EXC_CODE_OV;
          exl_q   <= 1'b1;
        end
        S_FLUSH: begin
          state_q    <= S_VEC;
          redir_q    <= 1'b1;
          redir_pc_q <= HANDLER_VEC;
        end
        S_VEC: if (pc_ack_i) begin
          state_q    <= S_HANDLER;
          redir_q    <= 1'b0;
          redir_pc_q <= '0;
        end
        S_HANDLER: if (eret_i) begin
          state_q <= S_RET;
          flush_q <= 1'b1;
          exl_q   <= 1'b0;
        end
        S_RET: begin
          // First RET cycle is the flush cycle; the redirect to EPC follows it.
          if (!redir_q) begin
            redir_q    <= 1'b1;
            redir_pc_q <= epc_q;
          end else if (pc_ack_i) begin
            state_q    <= S_IDLE;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_missed (
    .clk_i   (clk_i),
    .clear_i (!rst_n_i),
    .inc_i   (missed),
    .cnt_o   (missed_cnt_o)
  );

  assign flush_o       = flush_q;
  assign redirect_o    = redir_q;
  assign redirect_pc_o = redir_pc_q;
  assign epc_o         = epc_q;
  assign cause_o       = cause_q;
  assign exl_o         = exl_q;

endmodule

// File: tb/tb_overflow_exception_unit.sv
// Directed bench: two instances share stimulus, one with an 8-bit and one with a 2-bit missed counter.
module tb_overflow_exception_unit;

  localparam logic [31:0] HVEC = 32'h8000_0180;

  logic        clk_i = 1'b0;
  logic        rst_n_i, ex_valid_i, trap_en_i, ovf_i, eret_i, pc_ack_i;
  logic [31:0] ex_pc_i;

  logic        flush_o, redirect_o, exl_o;
  logic [31:0] redirect_pc_o, epc_o;
  logic [4:0]  cause_o;
  logic [7:0]  missed_cnt_o;

  logic        flush2, redirect2, exl2;
  logic [31:0] redirect_pc2, epc2;
  logic [4:0]  cause2;
  logic [1:0]  missed2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  overflow_exception_unit u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ex_valid_i(ex_valid_i), .trap_en_i(trap_en_i),
    .ovf_i(ovf_i), .ex_pc_i(ex_pc_i), .eret_i(eret_i), .pc_ack_i(pc_ack_i),
    .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .epc_o(epc_o), .cause_o(cause_o), .exl_o(exl_o), .missed_cnt_o(missed_cnt_o)
  );

  overflow_exception_unit #(.CNT_W(2)) u_dut2 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ex_valid_i(ex_valid_i), .trap_en_i(trap_en_i),
    .ovf_i(ovf_i), .ex_pc_i(ex_pc_i), .eret_i(eret_i), .pc_ack_i(pc_ack_i),
    .flush_o(flush2), .redirect_o(redirect2), .redirect_pc_o(redirect_pc2),
    .epc_o(epc2), .cause_o(cause2), .exl_o(exl2), .missed_cnt_o(missed2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs set now are sampled at the next edge; outputs read after return reflect that edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic v, input logic t, input logic o, input logic e, input logic a);
    ex_valid_i = v; trap_en_i = t; ovf_i = o; eret_i = e; pc_ack_i = a;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".flush"},  32'(flush_o),      32'd0);
    chk({tag, ".redir"},  32'(redirect_o),   32'd0);
    chk({tag, ".rpc"},    redirect_pc_o,     32'd0);
    chk({tag, ".epc"},    epc_o,             32'd0);
    chk({tag, ".cause"},  32'(cause_o),      32'd0);
    chk({tag, ".exl"},    32'(exl_o),        32'd0);
    chk({tag, ".miss"},   32'(missed_cnt_o), 32'd0);
    chk({tag, ".miss2"},  32'(missed2),      32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0; ex_pc_i = 32'h0;
    set_in(0, 0, 0, 0, 0);
    tick(); tick();
    chk_zero("reset");
    rst_n_i = 1'b1;

    // Overflow on addu / invalid slot is ignored
    ex_pc_i = 32'h0000_0100;
    set_in(1, 0, 1, 0, 0); tick();
    chk("addu.flush", 32'(flush_o), 0);
    set_in(0, 1, 1, 0, 0); tick();
    chk("inval.flush", 32'(flush_o), 0);
    set_in(0, 0, 0, 0, 0); tick();
    chk("addu.redir", 32'(redirect_o), 0);
    chk("addu.exl",   32'(exl_o), 0);
    chk("addu.miss",  32'(missed_cnt_o), 0);

    // Stray eret in IDLE
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk_zero("eret_idle");

    // Taken overflow: trig cycle N, flush N+1, redirect N+2 acked in N+2
    ex_pc_i = 32'h0040_0010;
    set_in(1, 1, 1, 0, 0); tick();
    chk("take.flush", 32'(flush_o), 1);
    chk("take.redir0", 32'(redirect_o), 0);
    chk("take.epc",   epc_o, 32'h0040_0010);
    chk("take.cause", 32'(cause_o), 12);
    chk("take.exl",   32'(exl_o), 1);
    set_in(0, 0, 0, 0, 0); tick();
    chk("take.flush_off", 32'(flush_o), 0);
    chk("take.redir", 32'(redirect_o), 1);
    chk("take.rpc",   redirect_pc_o, HVEC);
    set_in(0, 0, 0, 0, 1); tick();
    chk("take.ack", 32'(redirect_o), 0);
    chk("take.exl_h", 32'(exl_o), 1);

    // Nested: 3 trigs in HANDLER, then eret + trig together
    set_in(0, 0, 0, 0, 0);
    ex_pc_i = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 0, 0); tick();
    end
    chk("nest.miss3", 32'(missed_cnt_o), 3);
    chk("nest.flush0", 32'(flush_o), 0);
    chk("nest.epc_keep", epc_o, 32'h0040_0010);
    set_in(1, 1, 1, 1, 0); tick();
    chk("nest.miss4", 32'(missed_cnt_o), 4);
    chk("nest.sat2",  32'(missed2), 3);
    chk("nest.flush", 32'(flush_o), 1);
    chk("nest.exl",   32'(exl_o), 0);
    chk("nest.redir_off", 32'(redirect_o), 0);
    set_in(0, 0, 0, 0, 0); tick();
    chk("ret.flush_off", 32'(flush_o), 0);
    chk("ret.redir", 32'(redirect_o), 1);
    chk("ret.rpc",   redirect_pc_o, 32'h0040_0010);
    set_in(0, 0, 0, 0, 1); tick();
    chk("ret.ack",   32'(redirect_o), 0);
    chk("ret.rpc0",  redirect_pc_o, 32'd0);
    chk("ret.epc",   epc_o, 32'h0040_0010);

    // Delayed ack: redirect held 5 cycles
    ex_pc_i = 32'h0040_0020;
    set_in(1, 1, 1, 0, 0); tick();
    chk("dly.flush", 32'(flush_o), 1);
    chk("dly.epc",   epc_o, 32'h0040_0020);
    set_in(0, 0, 0, 0, 0); tick();
    chk("dly.redir0", 32'(redirect_o), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("dly.redir%0d", i + 1), 32'(redirect_o), 1);
      chk($sformatf("dly.rpc%0d", i + 1), redirect_pc_o, HVEC);
      chk($sformatf("dly.flush%0d", i + 1), 32'(flush_o), 0);
    end
    set_in(0, 0, 0, 0, 1); tick();
    chk("dly.redir_off", 32'(redirect_o), 0);
    chk("dly.rpc_off",   redirect_pc_o, 32'd0);

    // Saturation: 5 more trigs in HANDLER
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 1, 0, 0); tick();
    end
    chk("sat.miss8", 32'(missed_cnt_o), 9);
    chk("sat.miss2", 32'(missed2), 3);
    chk("sat.exl",   32'(exl_o), 1);

    // Return, then reset mid-VEC
    set_in(0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1); tick();
    ex_pc_i = 32'h0040_0030;
    set_in(1, 1, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk("rst.redir_pre", 32'(redirect_o), 1);
    rst_n_i = 1'b0; tick();
    chk_zero("rst_vec");
    rst_n_i = 1'b1; tick();
    chk("rst.idle_redir", 32'(redirect_o), 0);
    chk("rst.idle_flush", 32'(flush_o), 0);
    chk("rst.idle_exl",   32'(exl_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
